// File: rtl/cl_pcim_writer_pkg.sv
// Shared constants and FSM encoding for the PCIM stream writer.
package cl_pcim_writer_pkg;
  localparam int         BEAT_BYTES = 64;
  localparam logic [2:0] AWSIZE_512 = 3'h6;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} wr_state_e;
endpackage

// File: rtl/cl_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module cl_sync_fifo
  import cl_pcim_writer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           clk_main_a0,
  input  logic                           rst_main_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_fire, rd_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_fire) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_fire) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_fire, rd_fire})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_main_a0) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = cnt;
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
endmodule

// File: rtl/cl_pcim_stream_writer.sv
// Buffers a 512-bit result stream and writes it into a host ring buffer
// as AXI4 INCR bursts, reporting committed progress back to software.
module cl_pcim_stream_writer
  import cl_pcim_writer_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 16,
  parameter int MAX_BEATS = 64,
  parameter int MAX_OUTST = 4,
  parameter int FLUSH_CYC = 256
) (
  input  logic                clk_main_a0,
  input  logic                rst_main_n,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                cfg_enable,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [31:0]         cfg_ring_beats,
  input  logic [31:0]         cfg_host_ptr,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [31:0]         sts_done_ptr,
  output logic                sts_err,
  output logic [2:0]          sts_outst
);
  localparam int FIFO_DEPTH = 2 * MAX_BEATS;
  localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int LCNT_W     = $clog2(MAX_OUTST + 1);
  localparam int LEN_W      = 7;
  localparam int IDLE_W     = $clog2(FLUSH_CYC + 1);

  wr_state_e         state, state_nxt;
  logic [31:0]       issue_ptr, wrap_off, wrap_sum, done_ptr;
  logic [31:0]       space, room, n_calc;
  logic [LEN_W-1:0]  n_p0, beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [2:0]        outst;
  logic              err;
  logic [ADDR_W-1:0] awaddr_p0;
  logic [7:0]        awlen_p0;
  logic              issue, in_acc, w_acc, b_pop;
  logic              awvalid, wvalid, wlast;

  logic [DATA_W-1:0] fifo_head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;
  logic [LEN_W-1:0]  lq_head;
  logic [LCNT_W-1:0] lq_count;
  logic              lq_full, lq_empty;
  logic              unused_sigs;

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  cl_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .wr_en       (s_axis_tvalid),
    .wr_data     (s_axis_tdata),
    .rd_en       (w_acc),
    .rd_data     (fifo_head),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  // Length of every issued burst, retired in order by its B response.
  cl_sync_fifo #(.WIDTH(LEN_W), .DEPTH(MAX_OUTST)) u_len_queue (
    .clk_main_a0 (clk_main_a0),
    .rst_main_n  (rst_main_n),
    .wr_en       (issue),
    .wr_data     (LEN_W'(n_calc)),
    .rd_en       (m_axi_bvalid),
    .rd_data     (lq_head),
    .count       (lq_count),
    .full        (lq_full),
    .empty       (lq_empty)
  );

  assign in_acc = s_axis_tvalid && !fifo_full;
  assign w_acc  = wvalid && m_axi_wready;
  assign b_pop  = m_axi_bvalid && !lq_empty;

  // Burst sizing: limited by buffered data, burst cap, ring end and host space.
  always_comb begin
    space  = cfg_ring_beats - (issue_ptr - cfg_host_ptr);
    room   = cfg_ring_beats - wrap_off;
    n_calc = min32(min32(32'(fifo_count), 32'(MAX_BEATS)), min32(room, space));
    issue  = (state == IDLE) && cfg_enable && (outst < 3'(MAX_OUTST)) && (n_calc != '0) &&
             ((fifo_count >= FCNT_W'(MAX_BEATS)) || (idle_cnt == IDLE_W'(FLUSH_CYC)));
    wrap_sum = wrap_off + n_calc;
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    case (state)
      IDLE: if (issue) state_nxt = ADDR;
      ADDR: begin
        awvalid = 1'b1;
        if (m_axi_awready) state_nxt = DATA;
      end
      DATA: begin
        wvalid = 1'b1;
        wlast  = (beat_cnt == n_p0 - LEN_W'(1));
        if (wlast && m_axi_wready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: pointer bookkeeping and beat/idle counters.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      issue_ptr <= '0;
      wrap_off  <= '0;
      n_p0      <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      if (issue) begin
        issue_ptr <= issue_ptr + n_calc;
        wrap_off  <= (wrap_sum >= cfg_ring_beats) ? '0 : wrap_sum;
        n_p0      <= LEN_W'(n_calc);
        beat_cnt  <= '0;
      end else if (w_acc) begin
        beat_cnt  <= beat_cnt + LEN_W'(1);
      end
      if (in_acc || issue)                    idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(FLUSH_CYC)) idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (issue) begin
      awaddr_p0 <= cfg_base_addr + (ADDR_W'(wrap_off) * ADDR_W'(BEAT_BYTES));
      awlen_p0  <= 8'(n_calc - 32'd1);
    end
  end

  // Response stage: retire bursts and accumulate committed beats.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      outst    <= '0;
      done_ptr <= '0;
      err      <= 1'b0;
    end else begin
      case ({issue, b_pop})
        2'b10:   outst <= outst + 3'd1;
        2'b01:   outst <= outst - 3'd1;
        default: ;
      endcase
      if (b_pop) done_ptr <= done_ptr + 32'(lq_head);
      if (m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) err <= 1'b1;
    end
  end

  assign s_axis_tready = !fifo_full;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = awaddr_p0;
  assign m_axi_awlen   = awlen_p0;
  assign m_axi_awsize  = AWSIZE_512;
  assign m_axi_awvalid = awvalid;
  assign m_axi_wdata   = fifo_head;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast;
  assign m_axi_wvalid  = wvalid;
  assign m_axi_bready  = 1'b1;
  assign sts_done_ptr  = done_ptr;
  assign sts_err       = err;
  assign sts_outst     = outst;

  assign unused_sigs = ^{m_axi_bid, lq_count, lq_full, fifo_empty};
endmodule

// File: tb/tb_cl_pcim_stream_writer.sv
// Self-checking bench for cl_pcim_stream_writer: data/AW scoreboards plus
// a table of ring/burst-sizing scenarios and hand-written corner cases.
module tb_cl_pcim_stream_writer;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int ID_W   = 16;

  logic                clk_main_a0 = 1'b0;
  logic                rst_main_n  = 1'b0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tready;
  logic [DATA_W-1:0]   s_axis_tdata = '0;
  logic                cfg_enable = 1'b1;
  logic [ADDR_W-1:0]   cfg_base_addr = 64'h1000_0000;
  logic [31:0]         cfg_ring_beats = 32'd1024;
  logic [31:0]         cfg_host_ptr = 32'd0;
  logic [ID_W-1:0]     m_axi_awid;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic                m_axi_awvalid;
  logic                m_axi_awready = 1'b0;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready = 1'b1;
  logic [ID_W-1:0]     m_axi_bid = '0;
  logic [1:0]          m_axi_bresp = 2'b00;
  logic                m_axi_bvalid = 1'b0;
  logic                m_axi_bready;
  logic [31:0]         sts_done_ptr;
  logic                sts_err;
  logic [2:0]          sts_outst;

  cl_pcim_stream_writer dut (
    .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .cfg_enable(cfg_enable), .cfg_base_addr(cfg_base_addr),
    .cfg_ring_beats(cfg_ring_beats), .cfg_host_ptr(cfg_host_ptr),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .sts_done_ptr(sts_done_ptr), .sts_err(sts_err), .sts_outst(sts_outst)
  );

  always #5 clk_main_a0 = ~clk_main_a0;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    bit          rst;
    int          ring;
    logic [63:0] base;
    int          host;
    int          nbeats;
    int          nexp;
    logic [7:0]  len0;
    logic [63:0] addr0;
    logic [7:0]  len1;
    logic [63:0] addr1;
    int          done;
  } vec_t;

  vec_t              tbl[7];
  logic [DATA_W-1:0] exp_data[$];
  aw_t               exp_aw[$];
  int                n_pass = 0, n_total = 0;
  int                aw_count = 0, b_issued = 0, b_sent = 0;
  int                aw_delay = 0, aw_cnt = 0, w_mode = 0, last_beats = 0, w_idx = 0;
  logic [7:0]        cur_len = '0;
  bit                b_hold = 0, aw_stall = 0, w_stall = 0, st_last = 0;
  logic [1:0]        b_resp_val = 2'b00;
  logic [DATA_W-1:0] st_data = '0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk_main_a0); #1; end
  endtask

  task automatic do_reset();
    rst_main_n = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_data.delete();
    exp_aw.delete();
    b_issued = 0; b_sent = 0; aw_count = 0; w_idx = 0; cur_len = '0;
    aw_stall = 0; w_stall = 0;
    cyc(3);
    rst_main_n = 1'b1;
    cyc(2);
  endtask

  task automatic send_beats(input int n);
    logic [DATA_W-1:0] d;
    bit ok;
    int tries;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < DATA_W / 32; j++) d[j*32 +: 32] = $urandom;
      s_axis_tdata = d;
      s_axis_tvalid = 1'b1;
      tries = 0;
      do begin
        @(negedge clk_main_a0);
        ok = s_axis_tready;
        @(posedge clk_main_a0); #1;
        tries++;
      end while (!ok && tries < 4000);
      if (ok) exp_data.push_back(d);
      else begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_aw(input int target, input int budget);
    int t = 0;
    while (aw_count < target && t < budget) begin cyc(1); t++; end
    chk("aw_wait", aw_count, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (sts_done_ptr != target && t < budget) begin cyc(1); t++; end
    chk("done_wait", sts_done_ptr, target);
  endtask

  task automatic monitor();
    aw_t e;
    forever begin
      @(negedge clk_main_a0);
      if (!rst_main_n) begin
        aw_stall = 0;
        w_stall  = 0;
      end else begin
        if (aw_stall) chk("aw_hold", m_axi_awvalid, 1);
        if (m_axi_awvalid && m_axi_awready) begin
          if (exp_aw.size() == 0) chk("aw_unexpected", m_axi_awaddr, 0);
          else begin
            e = exp_aw.pop_front();
            chk("awaddr", m_axi_awaddr, e.addr);
            chk("awlen", m_axi_awlen, e.len);
          end
          chk("awsize", m_axi_awsize, 3'h6);
          chk("awid", m_axi_awid, 0);
          cur_len = m_axi_awlen;
          w_idx = 0;
          aw_count++;
        end
        aw_stall = m_axi_awvalid && !m_axi_awready;
        if (w_stall) begin
          chk("w_hold_valid", m_axi_wvalid, 1);
          chk("w_hold_data", m_axi_wdata, st_data);
          chk("w_hold_last", m_axi_wlast, st_last);
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (exp_data.size() == 0) chk("w_unexpected", m_axi_wdata, 0);
          else chk("wdata", m_axi_wdata, exp_data.pop_front());
          chk("wlast", m_axi_wlast, (w_idx == int'(cur_len)));
          chk("wstrb", m_axi_wstrb, {(DATA_W/8){1'b1}});
          w_idx++;
          if (m_axi_wlast) begin
            last_beats = w_idx;
            b_issued++;
          end
        end
        w_stall = m_axi_wvalid && !m_axi_wready;
        st_data = m_axi_wdata;
        st_last = m_axi_wlast;
      end
    end
  endtask

  task automatic responder();
    forever begin
      @(posedge clk_main_a0); #1;
      if (!rst_main_n) begin
        m_axi_awready = 1'b0;
        m_axi_bvalid  = 1'b0;
        aw_cnt = 0;
      end else begin
        if (m_axi_awvalid) begin
          m_axi_awready = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          m_axi_awready = 1'b0;
          aw_cnt = 0;
        end
        case (w_mode)
          0:       m_axi_wready = 1'b1;
          1:       m_axi_wready = !m_axi_wready;
          default: m_axi_wready = 1'b0;
        endcase
        m_axi_bresp = b_resp_val;
        if (!b_hold && b_issued > b_sent) begin
          m_axi_bvalid = 1'b1;
          b_sent++;
        end else begin
          m_axi_bvalid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int target, tries;
    tbl[0] = '{1, 1024, 64'h1000_0000, 0,   128, 2, 8'd63, 64'h1000_0000, 8'd63, 64'h1000_1000, 128};
    tbl[1] = '{1, 64,   64'h3000_0000, 0,   100, 1, 8'd63, 64'h3000_0000, 8'd0,  64'h0,         64};
    tbl[2] = '{0, 64,   64'h3000_0000, 64,  0,   1, 8'd35, 64'h3000_0000, 8'd0,  64'h0,         100};
    tbl[3] = '{1, 128,  64'h2000_0000, 0,   10,  1, 8'd9,  64'h2000_0000, 8'd0,  64'h0,         10};
    tbl[4] = '{0, 128,  64'h2000_0000, 0,   64,  1, 8'd63, 64'h2000_0280, 8'd0,  64'h0,         74};
    tbl[5] = '{0, 128,  64'h2000_0000, 0,   64,  1, 8'd53, 64'h2000_1280, 8'd0,  64'h0,         128};
    tbl[6] = '{0, 128,  64'h2000_0000, 128, 0,   1, 8'd9,  64'h2000_0000, 8'd0,  64'h0,         138};

    fork
      monitor();
      responder();
    join_none

    do_reset();
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_wlast", m_axi_wlast, 0);
    chk("rst_bready", m_axi_bready, 1);
    chk("rst_done", sts_done_ptr, 0);
    chk("rst_err", sts_err, 0);
    chk("rst_outst", sts_outst, 0);
    chk("rst_tready", s_axis_tready, 1);

    for (int r = 0; r < 7; r++) begin
      cfg_ring_beats = tbl[r].ring;
      cfg_base_addr  = tbl[r].base;
      if (tbl[r].rst) do_reset();
      cfg_host_ptr = tbl[r].host;
      exp_aw.push_back('{addr: tbl[r].addr0, len: tbl[r].len0});
      if (tbl[r].nexp > 1) exp_aw.push_back('{addr: tbl[r].addr1, len: tbl[r].len1});
      target = aw_count + tbl[r].nexp;
      if (tbl[r].nbeats > 0) send_beats(tbl[r].nbeats);
      wait_aw(target, 1000);
      cyc(300);
      chk("row_aw_count", aw_count, target);
      chk("row_done", sts_done_ptr, tbl[r].done);
    end

    // Partial burst waits out the full idle window before flushing.
    cfg_ring_beats = 1024; cfg_base_addr = 64'h1000_0000; cfg_host_ptr = 0;
    do_reset();
    exp_aw.push_back('{addr: 64'h1000_0000, len: 8'd9});
    send_beats(10);
    cyc(250);
    chk("flush_early", aw_count, 0);
    wait_aw(1, 200);
    wait_done(10, 200);

    // Slow AW acceptance and W back-pressure.
    do_reset();
    aw_delay = 20; w_mode = 1;
    exp_aw.push_back('{addr: 64'h1000_0000, len: 8'd63});
    send_beats(64);
    wait_aw(1, 500);
    wait_done(64, 1000);
    chk("bp_beats", last_beats, 64);
    aw_delay = 0; w_mode = 0;

    // Outstanding limit, then error response.
    do_reset();
    b_hold = 1;
    for (int k = 0; k < 5; k++) exp_aw.push_back('{addr: 64'h1000_0000 + 64'(k) * 64'h1000, len: 8'd63});
    send_beats(320);
    cyc(300);
    chk("outst_aw", aw_count, 4);
    chk("outst_cnt", sts_outst, 4);
    chk("outst_err_clear", sts_err, 0);
    b_resp_val = 2'b10;
    b_hold = 0;
    wait_aw(5, 500);
    wait_done(320, 2000);
    chk("err_sticky", sts_err, 1);
    chk("outst_drained", sts_outst, 0);
    b_resp_val = 2'b00;

    // cfg_enable gates issue only.
    do_reset();
    cfg_enable = 1'b0;
    exp_aw.push_back('{addr: 64'h1000_0000, len: 8'd63});
    send_beats(64);
    cyc(300);
    chk("en_block", aw_count, 0);
    cfg_enable = 1'b1;
    wait_aw(1, 100);
    wait_done(64, 500);

    // Reset while a burst is stalled in DATA.
    do_reset();
    w_mode = 2;
    exp_aw.push_back('{addr: 64'h1000_0000, len: 8'd63});
    send_beats(64);
    tries = 0;
    while (!m_axi_wvalid && tries < 500) begin cyc(1); tries++; end
    chk("mid_in_data", m_axi_wvalid, 1);
    cyc(3);
    chk("mid_fifo_pre", dut.u_data_fifo.count, 64);
    chk("mid_outst_pre", sts_outst, 1);
    rst_main_n = 1'b0;
    #1;
    chk("mid_awvalid", m_axi_awvalid, 0);
    chk("mid_wvalid", m_axi_wvalid, 0);
    chk("mid_wlast", m_axi_wlast, 0);
    chk("mid_outst", sts_outst, 0);
    chk("mid_done", sts_done_ptr, 0);
    chk("mid_fifo", dut.u_data_fifo.count, 0);
    w_mode = 0;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
